// File: rtl/regfile_param.sv
// regfile_param: parameterised multi-read-port register file with a clear
// sequencer and a registered debug read port.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a same-cycle
// write is forwarded to any read port that addresses the written entry.
// Entry 0 is hard-wired to zero on every read path and is never written.
module regfile_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWriteW,
    input  logic [AW-1:0]       RdW,
    input  logic [XLEN-1:0]     ResultW,
    input  logic [NRD*AW-1:0]   A,
    output logic [NRD*XLEN-1:0] RD,
    input  logic                ClearReq,
    output logic                Busy,
    input  logic                DbgReq,
    input  logic [AW-1:0]       DbgAddr,
    output logic                DbgAck,
    output logic [XLEN-1:0]     DbgData
);

    localparam logic [0:0]    S_CLEAR = 1'b0;
    localparam logic [0:0]    S_READY = 1'b1;
    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREGS - 1);

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            dbg_ack_q, dbg_ack_d;
    logic [XLEN-1:0] dbg_data_q, dbg_data_d;

    // Storage has no reset: the clear sequencer zeroes entries 1..NREGS-1.
    logic [XLEN-1:0] mem_q [NREGS];

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    // Next-state, array write port and debug read decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we         = 1'b0;
        waddr      = RdW;
        wdata      = ResultW;
        dbg_ack_d  = 1'b0;
        dbg_data_d = dbg_data_q;
        case (state_q)
            S_CLEAR: begin
                // One entry per cycle; the edge writing the last entry exits.
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST)
                    state_d = S_READY;
            end
            default: begin
                // A clear request wins over a coincident write.
                if (ClearReq) begin
                    state_d = S_CLEAR;
                    cnt_d   = CNT_FIRST;
                end else if (RegWriteW && (RdW != '0)) begin
                    we = 1'b1;
                end
                // Suppress an ack right after an ack so a held request
                // completes every other cycle. Reads the stored array only.
                if (DbgReq && !dbg_ack_q) begin
                    dbg_ack_d  = 1'b1;
                    dbg_data_d = (DbgAddr == '0) ? '0 : mem_q[DbgAddr];
                end
            end
        endcase
    end

    // Control and debug registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            cnt_q      <= CNT_FIRST;
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dbg_ack_q  <= dbg_ack_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    // Array write port; held off during reset so reset never touches storage.
    always_ff @(posedge clk) begin
        if (!rst && we)
            mem_q[waddr] <= wdata;
    end

    assign Busy    = (state_q == S_CLEAR);
    assign DbgAck  = dbg_ack_q;
    assign DbgData = dbg_data_q;

    // Combinational read ports; zero while clearing or for entry 0.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a_i;
        logic [XLEN-1:0] rd_i;
        assign a_i = A[i*AW +: AW];
        // Per-port read mux with optional write forwarding.
        always_comb begin
            rd_i = mem_q[a_i];
            if ((state_q == S_CLEAR) || (a_i == '0))
                rd_i = '0;
`ifdef REGFILE_BYPASS_EN
            else if (RegWriteW && (RdW != '0) && (RdW == a_i))
                rd_i = ResultW;
`endif
        end
        assign RD[i*XLEN +: XLEN] = rd_i;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (default parameters).
// Expected read data during a write cycle follows REGFILE_BYPASS_EN.
module tb_regfile_param;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                RegWriteW;
    logic [AW-1:0]       RdW;
    logic [XLEN-1:0]     ResultW;
    logic [NRD*AW-1:0]   A;
    logic [NRD*XLEN-1:0] RD;
    logic                ClearReq;
    logic                Busy;
    logic                DbgReq;
    logic [AW-1:0]       DbgAddr;
    logic                DbgAck;
    logic [XLEN-1:0]     DbgData;

    int total = 0;
    int bad = 0;

    regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A(A), .RD(RD), .ClearReq(ClearReq), .Busy(Busy), .DbgReq(DbgReq),
        .DbgAddr(DbgAddr), .DbgAck(DbgAck), .DbgData(DbgData)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        A = {a1, a0};
    endtask

    // Counts Busy cycles until READY; bounded, returns -1 on timeout.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (!Busy) return;
            n++;
            tick();
        end
        n = -1;
    endtask

    task automatic test_reset();
        int n;
        logic zero_ok;
        rst = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultW = '0; ClearReq = 1'b0;
        DbgReq = 1'b0; DbgAddr = '0; set_a(5'd5, 5'd31);
        repeat (2) tick();
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", Busy); end
        total++; if (DbgAck !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", DbgAck); end
        total++; if (DbgData !== 32'h0) begin bad++; $display("FAIL reset_dbgdata got=%h exp=0", DbgData); end
        rst = 1'b0;
        n = 0;
        zero_ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (!Busy) break;
            n++;
            if (RD !== 64'h0) zero_ok = 1'b0;
            tick();
        end
        total++; if (n !== 31) begin bad++; $display("FAIL reset_busy_cycles got=%0d exp=31", n); end
        total++; if (zero_ok !== 1'b1) begin bad++; $display("FAIL reset_rd_zero got=nonzero exp=0"); end
        total++; if (RD !== 64'h0) begin bad++; $display("FAIL ready_rd_cleared got=%h exp=0", RD); end
    endtask

    task automatic test_write();
        logic [XLEN-1:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        set_a(5'd5, 5'd0);
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
        #1;
        total++; if (RD[31:0] !== exp_same) begin bad++; $display("FAIL write_same_cycle got=%h exp=%h", RD[31:0], exp_same); end
        tick();
        RegWriteW = 1'b0;
        #1;
        total++; if (RD[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL write_next_cycle got=%h exp=deadbeef", RD[31:0]); end
        // Second port sees the same entry; another entry stays untouched.
        set_a(5'd6, 5'd5);
        #1;
        total++; if (RD !== {32'hDEADBEEF, 32'h0}) begin bad++; $display("FAIL write_two_ports got=%h exp=deadbeef00000000", RD); end
    endtask

    task automatic test_x0();
        set_a(5'd5, 5'd0);
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234;
        #1;
        total++; if (RD[63:32] !== 32'h0) begin bad++; $display("FAIL x0_same_cycle got=%h exp=0", RD[63:32]); end
        tick();
        RegWriteW = 1'b0;
        #1;
        total++; if (RD[63:32] !== 32'h0) begin bad++; $display("FAIL x0_next_cycle got=%h exp=0", RD[63:32]); end
        DbgReq = 1'b1; DbgAddr = 5'd0;
        tick();
        DbgReq = 1'b0;
        total++; if ({DbgAck, DbgData} !== {1'b1, 32'h0}) begin bad++; $display("FAIL x0_dbg got=%b/%h exp=1/0", DbgAck, DbgData); end
        tick();
    endtask

    task automatic test_back_to_back();
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'hA5A5_0009;
        tick();
        RegWriteW = 1'b0;
        DbgReq = 1'b1; DbgAddr = 5'd5;
        tick();
        total++; if ({DbgAck, DbgData} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL dbg_first got=%b/%h exp=1/deadbeef", DbgAck, DbgData); end
        DbgAddr = 5'd9;
        tick();
        total++; if ({DbgAck, DbgData} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL dbg_gap got=%b/%h exp=0/deadbeef", DbgAck, DbgData); end
        tick();
        total++; if ({DbgAck, DbgData} !== {1'b1, 32'hA5A50009}) begin bad++; $display("FAIL dbg_second got=%b/%h exp=1/a5a50009", DbgAck, DbgData); end
        DbgReq = 1'b0;
        tick();
        total++; if (DbgAck !== 1'b0) begin bad++; $display("FAIL dbg_release got=%b exp=0", DbgAck); end
    endtask

    task automatic test_clear();
        int n;
        logic ack_seen;
        // x7 first holds a known nonzero value.
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h11;
        tick();
        ClearReq = 1'b1; ResultW = 32'h55;
        tick();
        ClearReq = 1'b0; RegWriteW = 1'b0;
        n = 0;
        ack_seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!Busy) break;
            n++;
            if (k == 2) begin DbgReq = 1'b1; DbgAddr = 5'd5; end
            if (k == 5) ClearReq = 1'b1;
            if (k == 20) begin RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33; end
            if (DbgAck !== 1'b0) ack_seen = 1'b1;
            tick();
            ClearReq = 1'b0; RegWriteW = 1'b0;
        end
        total++; if (n !== 31) begin bad++; $display("FAIL clear_busy_cycles got=%0d exp=31", n); end
        total++; if (ack_seen !== 1'b0) begin bad++; $display("FAIL clear_dbg_held got=ack exp=none"); end
        total++; if (DbgAck !== 1'b0) begin bad++; $display("FAIL clear_dbg_first_ready got=%b exp=0", DbgAck); end
        tick();
        DbgReq = 1'b0;
        total++; if ({DbgAck, DbgData} !== {1'b1, 32'h0}) begin bad++; $display("FAIL clear_dbg_ack got=%b/%h exp=1/0", DbgAck, DbgData); end
        set_a(5'd7, 5'd3);
        #1;
        total++; if (RD !== 64'h0) begin bad++; $display("FAIL clear_x7_x3 got=%h exp=0", RD); end
        count_busy(n);
    endtask

    task automatic test_rst_mid();
        int n;
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        total++; if (n !== 31) begin bad++; $display("FAIL rst_mid_clear got=%0d exp=31", n); end
        // Reset on the request cycle drops the ack.
        RegWriteW = 1'b1; RdW = 5'd6; ResultW = 32'h66;
        tick();
        RegWriteW = 1'b0;
        DbgReq = 1'b1; DbgAddr = 5'd6; rst = 1'b1;
        tick();
        rst = 1'b0; DbgReq = 1'b0;
        total++; if ({DbgAck, DbgData, Busy} !== {1'b0, 32'h0, 1'b1}) begin bad++; $display("FAIL rst_dbg got=%b/%h/%b exp=0/0/1", DbgAck, DbgData, Busy); end
        count_busy(n);
        total++; if (n !== 31) begin bad++; $display("FAIL rst_dbg_clear got=%0d exp=31", n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_x0();
        test_back_to_back();
        test_clear();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
